clint_irq_src: RTL and testbench

//  Machine interrupt source for the trap unit: drives the MTIP/MSIP/MEIP pending lines the trap logic samples.

---
 rtl/clint_irq_src_pkg.sv | 32 +++
 rtl/clint_tick.sv | 25 ++
 rtl/clint_irq_src.sv | 131 +++++++++++++
 tb/tb_clint_irq_src.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_irq_src_pkg.sv
// Shared CLINT register offsets, interrupt cause codes and mip bit positions.
// The trap unit imports the same package so both sides agree on the encodings.
package clint_irq_src_pkg;

  typedef enum logic [4:0] {
    OFF_MSIP        = 5'h00,
    OFF_MTIMECMP_LO = 5'h04,
    OFF_MTIMECMP_HI = 5'h08,
    OFF_MTIME_LO    = 5'h0C,
    OFF_MTIME_HI    = 5'h10,
    OFF_MEIP        = 5'h14
  } reg_off_e;

  typedef enum logic [4:0] {
    CAUSE_MSI = 5'd3,
    CAUSE_MTI = 5'd7,
    CAUSE_MEI = 5'd11
  } irq_cause_e;

  typedef enum logic [3:0] {
    MIP_MSIP_BIT = 4'd3,
    MIP_MTIP_BIT = 4'd7,
    MIP_MEIP_BIT = 4'd11
  } mip_bit_e;

  localparam logic [31:0] WINDOW_LAST = 32'h0000_0017;

  function automatic logic [31:0] bit_word(input logic b);
    return {31'b0, b};
  endfunction

endpackage

// File: rtl/clint_tick.sv
// Prescale counter for mtime: emits a one-cycle tick every PRESCALE clk cycles.
module clint_tick #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned   CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    tick    = (count_q == LAST);
    count_d = tick ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/clint_irq_src.sv
// Machine interrupt source: mtime/mtimecmp timer, MSIP bit and latched MEIP on the MEM-stage bus.
// Define CLINT_EXT_SYNC_EN to pass ext_irq through a 2-flop synchronizer before edge detection.
module clint_irq_src #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic        bus_re,
  input  logic        bus_we,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        bus_err,
  input  logic        ext_irq,
  input  logic        intr_ack,
  input  logic [4:0]  ack_cause,
  output logic        MSIP,
  output logic        MTIP,
  output logic        MEIP
);
  import clint_irq_src_pkg::*;

  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d, meip_q, meip_d, mtip_q, mtip_d;
  logic        rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ext_cond, ext_prev_q, ext_prev_d, ext_rise;
  logic        tick;
  logic [31:0] offset, rd_word;
  logic        in_window, aligned, wr_en, rd_en;

  clint_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef CLINT_EXT_SYNC_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], ext_irq};
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end
  assign ext_cond = sync_q[1];
`else
  assign ext_cond = ext_irq;
`endif

  assign ext_prev_d = ext_cond;
  assign ext_rise   = ext_cond & ~ext_prev_q;

  // The lower-bound test keeps addresses just below BASE_ADDR from wrapping into the window.
  assign offset    = bus_addr - BASE_ADDR;
  assign in_window = (bus_addr >= BASE_ADDR) && (offset <= WINDOW_LAST);
  assign aligned   = (bus_addr[1:0] == 2'b00);
  assign wr_en     = in_window && aligned && bus_we;
  assign rd_en     = in_window && aligned && bus_re && !bus_we;

  always_comb begin
    rd_word = '0;
    case (offset[4:0])
      OFF_MSIP:        rd_word = bit_word(msip_q);
      OFF_MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
      OFF_MTIMECMP_HI: rd_word = mtimecmp_q[63:32];
      OFF_MTIME_LO:    rd_word = mtime_q[31:0];
      OFF_MTIME_HI:    rd_word = mtime_q[63:32];
      OFF_MEIP:        rd_word = bit_word(meip_q);
      default:         rd_word = '0;
    endcase
  end

  // A bus write to either mtime half replaces that cycle's increment; the other half just holds.
  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    meip_d     = meip_q;
    if (wr_en) begin
      case (offset[4:0])
        OFF_MSIP:        msip_d = bus_wdata[0];
        OFF_MTIMECMP_LO: mtimecmp_d[31:0] = bus_wdata;
        OFF_MTIMECMP_HI: mtimecmp_d[63:32] = bus_wdata;
        OFF_MTIME_LO:    mtime_d = {mtime_q[63:32], bus_wdata};
        OFF_MTIME_HI:    mtime_d = {bus_wdata, mtime_q[31:0]};
        OFF_MEIP:        if (bus_wdata[0]) meip_d = 1'b0;
        default:         ;
      endcase
    end
    if (intr_ack && (ack_cause == CAUSE_MEI)) meip_d = 1'b0;
    if (ext_rise) meip_d = 1'b1;
    mtip_d   = (mtime_q >= mtimecmp_q);
    rvalid_d = rd_en;
    rdata_d  = rd_en ? rd_word : '0;
    err_d    = in_window && !aligned && (bus_re || bus_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      meip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      ext_prev_q <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      meip_q     <= meip_d;
      mtip_q     <= mtip_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      ext_prev_q <= ext_prev_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign bus_err    = err_q;
  assign MSIP       = msip_q;
  assign MTIP       = mtip_q;
  assign MEIP       = meip_q;

endmodule

// File: tb/tb_clint_irq_src.sv
// Self-checking bench for clint_irq_src: directed scenarios plus random traffic against a register-level model.
// Honours CLINT_EXT_SYNC_EN for the expected ext_irq-to-MEIP latency.
module tb_clint_irq_src;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int unsigned PRESC = 1;
`ifdef CLINT_EXT_SYNC_EN
  localparam int EXT_LAT = 3;
`else
  localparam int EXT_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_re, bus_we, bus_rvalid, bus_err;
  logic        ext_irq, intr_ack;
  logic [4:0]  ack_cause;
  logic        MSIP, MTIP, MEIP;

  always #5 clk = ~clk;

  clint_irq_src #(.BASE_ADDR(BASE), .PRESCALE(PRESC)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_re     (bus_re),
    .bus_we     (bus_we),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .bus_err    (bus_err),
    .ext_irq    (ext_irq),
    .intr_ack   (intr_ack),
    .ack_cause  (ack_cause),
    .MSIP       (MSIP),
    .MTIP       (MTIP),
    .MEIP       (MEIP)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: registers as plain numbers, plus a short history of sampled ext_irq.
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_meip;
  int unsigned m_presc;
  logic [3:0]  ext_hist;
  logic        e_rvalid, e_err, e_mtip;
  logic [31:0] e_rdata;

  logic [31:0] rd_val, rnd_addr, rnd_data;
  logic        rnd_re, rnd_we;
  int          lat, rise_at, kind;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] off);
    case (off)
      32'h00:  return {31'b0, m_msip};
      32'h04:  return m_cmp[31:0];
      32'h08:  return m_cmp[63:32];
      32'h0C:  return m_mtime[31:0];
      32'h10:  return m_mtime[63:32];
      32'h14:  return {31'b0, m_meip};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] off;
    logic        in_win, wr, tick, rise, clr;
    if (rst) begin
      m_mtime = '0; m_cmp = '1; m_msip = 1'b0; m_meip = 1'b0; m_presc = 0; ext_hist = '0;
      e_rvalid = 1'b0; e_rdata = '0; e_err = 1'b0; e_mtip = 1'b0;
      return;
    end
    off    = bus_addr - BASE;
    in_win = (bus_addr >= BASE) && (off < 32'd24);
    wr     = in_win && bus_we && (off % 4 == 0);
    e_rvalid = 1'b0; e_rdata = '0; e_err = 1'b0;
    if (in_win && (bus_re || bus_we)) begin
      if (off % 4 != 0) e_err = 1'b1;
      else if (!bus_we) begin
        e_rvalid = 1'b1;
        e_rdata  = model_read(off);
      end
    end
    e_mtip   = (m_mtime >= m_cmp);
    tick     = (m_presc == PRESC - 1);
    m_presc  = tick ? 0 : m_presc + 1;
    ext_hist = {ext_hist[2:0], ext_irq};
    rise     = ext_hist[EXT_LAT-1] && !ext_hist[EXT_LAT];
    clr      = (intr_ack && ack_cause == 5'd11) || (wr && off == 32'h14 && bus_wdata[0]);
    if (rise)     m_meip = 1'b1;
    else if (clr) m_meip = 1'b0;
    if (wr && off == 32'h0C)      m_mtime[31:0]  = bus_wdata;
    else if (wr && off == 32'h10) m_mtime[63:32] = bus_wdata;
    else if (tick)                m_mtime        = m_mtime + 64'd1;
    if (wr && off == 32'h00) m_msip        = bus_wdata[0];
    if (wr && off == 32'h04) m_cmp[31:0]   = bus_wdata;
    if (wr && off == 32'h08) m_cmp[63:32]  = bus_wdata;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    #1;
    checkOutput("rvalid", 64'(bus_rvalid), 64'(e_rvalid));
    checkOutput("rdata",  64'(bus_rdata),  64'(e_rdata));
    checkOutput("err",    64'(bus_err),    64'(e_err));
    checkOutput("mtip",   64'(MTIP),       64'(e_mtip));
    checkOutput("msip",   64'(MSIP),       64'(m_msip));
    checkOutput("meip",   64'(MEIP),       64'(m_meip));
  endtask

  task automatic applyStimulus(input logic re, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus_re = re; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    step_cycle();
    bus_re = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, BASE + off, data);
  endtask

  task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
    applyStimulus(1'b1, 1'b0, BASE + off, 32'h0);
    data = bus_rdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; bus_addr = '0; bus_re = 1'b0; bus_we = 1'b0; bus_wdata = '0;
    ext_irq = 1'b0; intr_ack = 1'b0; ack_cause = '0;
    step_cycle();
    step_cycle();
    rst = 1'b0;

    checkOutput("reset_irq_lines", 64'({MTIP, MSIP, MEIP}), 64'd0);
    bus_read(32'h04, rd_val);
    checkOutput("reset_cmp_lo", 64'(rd_val), 64'hFFFF_FFFF);
    checkOutput("reset_cmp_lo_rvalid", 64'(bus_rvalid), 64'd1);
    bus_read(32'h08, rd_val);
    checkOutput("reset_cmp_hi", 64'(rd_val), 64'hFFFF_FFFF);

    // Timer compare: MTIP must rise exactly 21 cycles after mtime restarts at 0 with mtimecmp=20.
    bus_write(32'h10, 32'h0);
    bus_write(32'h08, 32'h0);
    bus_write(32'h04, 32'd20);
    bus_write(32'h0C, 32'h0);
    rise_at = -1;
    for (int i = 1; i <= 40; i++) begin
      idle(1);
      if (MTIP && rise_at < 0) rise_at = i;
    end
    checkOutput("mtip_rise_cycle", 64'(rise_at), 64'd21);
    bus_write(32'h04, 32'd100);
    idle(1);
    checkOutput("mtip_clear_by_cmp", 64'(MTIP), 64'd0);

    // Low-word wrap carries into the high word; a write on a tick cycle keeps the written value.
    bus_write(32'h10, 32'h0);
    bus_write(32'h0C, 32'hFFFF_FFFF);
    idle(1);
    bus_read(32'h0C, rd_val);
    checkOutput("wrap_lo", 64'(rd_val), 64'd0);
    bus_read(32'h10, rd_val);
    checkOutput("wrap_hi", 64'(rd_val), 64'd1);
    bus_write(32'h0C, 32'h0000_1234);
    bus_read(32'h0C, rd_val);
    checkOutput("tick_write_lo", 64'(rd_val), 64'h1234);
    bus_read(32'h10, rd_val);
    checkOutput("tick_write_hi", 64'(rd_val), 64'd1);

    // External interrupt latency, selective acknowledge, and set-wins-over-clear.
    lat = -1;
    ext_irq = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      idle(1);
      ext_irq = 1'b0;
      if (MEIP && lat < 0) lat = i;
    end
    checkOutput("meip_latency", 64'(lat), 64'(EXT_LAT));
    intr_ack = 1'b1; ack_cause = 5'd7;
    idle(1);
    checkOutput("meip_ack_mti_keeps", 64'(MEIP), 64'd1);
    ack_cause = 5'd11;
    idle(1);
    intr_ack = 1'b0;
    checkOutput("meip_ack_mei_clears", 64'(MEIP), 64'd0);
    idle(4);
    ext_irq = 1'b1;
    idle(EXT_LAT - 1);
    intr_ack = 1'b1; ack_cause = 5'd11;
    idle(1);
    intr_ack = 1'b0; ext_irq = 1'b0;
    checkOutput("meip_set_wins", 64'(MEIP), 64'd1);
    bus_write(32'h14, 32'h0);
    checkOutput("meip_write0_keeps", 64'(MEIP), 64'd1);
    bus_write(32'h14, 32'h1);
    checkOutput("meip_write1_clears", 64'(MEIP), 64'd0);

    // Software interrupt bit and misaligned access.
    bus_write(32'h00, 32'h1);
    checkOutput("msip_set", 64'(MSIP), 64'd1);
    bus_write(32'h00, 32'h0);
    checkOutput("msip_clear", 64'(MSIP), 64'd0);
    bus_read(32'h02, rd_val);
    checkOutput("misaligned_err", 64'(bus_err), 64'd1);
    checkOutput("misaligned_rvalid", 64'(bus_rvalid), 64'd0);
    checkOutput("misaligned_rdata", 64'(rd_val), 64'd0);

    // Reset coincident with a read strobe drops the response.
    bus_re = 1'b1; bus_addr = BASE + 32'h04; rst = 1'b1;
    step_cycle();
    rst = 1'b0; bus_re = 1'b0;
    checkOutput("reset_drops_rvalid", 64'(bus_rvalid), 64'd0);
    bus_read(32'h0C, rd_val);
    checkOutput("reset_mtime_lo", 64'(rd_val), 64'd0);
    bus_read(32'h04, rd_val);
    checkOutput("reset_cmp_lo_again", 64'(rd_val), 64'hFFFF_FFFF);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      kind     = int'($urandom_range(0, 9));
      rnd_addr = BASE + 32'(4 * $urandom_range(0, 5));
      rnd_data = $urandom;
      rnd_re   = 1'b0;
      rnd_we   = 1'b0;
      if (kind >= 3 && kind < 6) rnd_re = 1'b1;
      else if (kind >= 6 && kind < 9) begin
        rnd_we = 1'b1;
        if (rnd_addr == BASE + 32'h04) rnd_data = m_mtime[31:0] + 32'($urandom_range(0, 40)) - 32'd20;
        if (rnd_addr == BASE + 32'h08 || rnd_addr == BASE + 32'h10) rnd_data = 32'($urandom_range(0, 1));
        if (rnd_addr == BASE + 32'h0C) rnd_data = m_cmp[31:0] + 32'($urandom_range(0, 40)) - 32'd20;
      end else if (kind == 9) begin
        rnd_re = 1'($urandom_range(0, 1));
        rnd_we = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: rnd_addr = BASE + 32'($urandom_range(0, 23));
          1: rnd_addr = BASE - 32'd4;
          2: rnd_addr = BASE + 32'd24;
          default: rnd_addr = 32'($urandom_range(0, 1023));
        endcase
      end
      if ($urandom_range(0, 3) == 0) ext_irq = ~ext_irq;
      intr_ack = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: ack_cause = 5'd3;
        1: ack_cause = 5'd7;
        2: ack_cause = 5'd11;
        default: ack_cause = 5'($urandom_range(0, 31));
      endcase
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(rnd_re, rnd_we, rnd_addr, rnd_data);
    end
    rst = 1'b0; intr_ack = 1'b0; ext_irq = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
